iob_asym_fifo_ctrl: RTL and testbench

Single-clock FIFO controller that sequences an asymmetric two-port RAM (`iob_t2p_asym_ram`) as a width-converting FIFO. It accepts words of W_DATA_W bits and delivers words of R_DATA_W bits, generating RAM write/read addresses, tracking occupancy in minimum-width units, and flagging full/empty. It sits between a producer and a consumer of different bus widths. The RAM is external to this block; the controller drives its ports.

---
 rtl/iob_asym_fifo_ctrl_pkg.sv | 27 ++
 rtl/iob_asym_fifo_level.sv | 44 ++++
 rtl/iob_asym_fifo_ctrl.sv | 102 ++++++++++
 tb/tb_iob_asym_fifo_ctrl.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/iob_asym_fifo_ctrl_pkg.sv
// Shared helpers for the asymmetric FIFO controller and RAM wrapper: clog2 and
// the width-ratio / address-width derivations.
`default_nettype none
package iob_asym_fifo_ctrl_pkg;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  function automatic int min_w(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  // Lanes of minimum width carried by one word of width 'this_w'.
  function automatic int ratio_of(input int this_w, input int other_w);
    return this_w / min_w(this_w, other_w);
  endfunction

  function automatic int port_addr_w(input int addr_w, input int ratio);
    return addr_w - clog2(ratio);
  endfunction

endpackage
`default_nettype wire

// File: rtl/iob_asym_fifo_level.sv
// Occupancy counter in minimum-width units with full/empty decode from the
// registered level only.
`default_nettype none
module iob_asym_fifo_level #(
  parameter int ADDR_W  = 4,
  parameter int W_RATIO = 2,
  parameter int R_RATIO = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            w_acc,
  input  logic            r_acc,
  output logic [ADDR_W:0] level,
  output logic            w_full,
  output logic            r_empty
);

  localparam logic [ADDR_W:0] W_INC    = (ADDR_W + 1)'(W_RATIO);
  localparam logic [ADDR_W:0] R_DEC    = (ADDR_W + 1)'(R_RATIO);
  localparam logic [ADDR_W:0] FULL_THR = (ADDR_W + 1)'((1 << ADDR_W) - W_RATIO);

  logic [ADDR_W:0] level_q;
  logic [ADDR_W:0] level_d;

  // Intermediate wrap is harmless: the final result always lies in 0..2^ADDR_W.
  always_comb begin
    level_d = level_q;
    if (w_acc) level_d = level_d + W_INC;
    if (r_acc) level_d = level_d - R_DEC;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     level_q <= '0;
    else if (flush) level_q <= '0;
    else            level_q <= level_d;
  end

  assign level   = level_q;
  assign w_full  = (level_q > FULL_THR);
  assign r_empty = (level_q < R_DEC);

endmodule
`default_nettype wire

// File: rtl/iob_asym_fifo_ctrl.sv
// Width-converting FIFO controller driving an external asymmetric 2-port RAM.
// Define IOB_ASYM_FIFO_CTRL_ERR_EN to add sticky w_overflow / r_underflow outputs.
`default_nettype none
module iob_asym_fifo_ctrl
  import iob_asym_fifo_ctrl_pkg::*;
#(
  parameter  int W_DATA_W = 16,
  parameter  int R_DATA_W = 8,
  parameter  int ADDR_W   = 4,
  localparam int W_RATIO  = ratio_of(W_DATA_W, R_DATA_W),
  localparam int R_RATIO  = ratio_of(R_DATA_W, W_DATA_W),
  localparam int W_ADDR_W = port_addr_w(ADDR_W, W_RATIO),
  localparam int R_ADDR_W = port_addr_w(ADDR_W, R_RATIO)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                w_en,
  input  logic [W_DATA_W-1:0] w_data,
  output logic                w_full,
  input  logic                r_en,
  output logic [R_DATA_W-1:0] r_data,
  output logic                r_valid,
  output logic                r_empty,
  output logic [ADDR_W:0]     level,
  output logic                mem_w_en,
  output logic [W_ADDR_W-1:0] mem_w_addr,
  output logic [W_DATA_W-1:0] mem_w_data,
  output logic                mem_r_en,
  output logic [R_ADDR_W-1:0] mem_r_addr,
  input  logic [R_DATA_W-1:0] mem_r_data
`ifdef IOB_ASYM_FIFO_CTRL_ERR_EN
  ,
  output logic                w_overflow,
  output logic                r_underflow
`endif
);

  logic [W_ADDR_W-1:0] wptr;
  logic [R_ADDR_W-1:0] rptr;
  logic                w_acc;
  logic                r_acc;

  // Requests are ignored during flush so the cleared state is not disturbed.
  assign w_acc = w_en & ~w_full & ~flush;
  assign r_acc = r_en & ~r_empty & ~flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr    <= '0;
      rptr    <= '0;
      r_valid <= 1'b0;
    end else if (flush) begin
      wptr    <= '0;
      rptr    <= '0;
      r_valid <= 1'b0;
    end else begin
      if (w_acc) wptr <= wptr + W_ADDR_W'(1);
      if (r_acc) rptr <= rptr + R_ADDR_W'(1);
      r_valid <= r_acc;
    end
  end

  iob_asym_fifo_level #(
    .ADDR_W  (ADDR_W),
    .W_RATIO (W_RATIO),
    .R_RATIO (R_RATIO)
  ) u_level (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (flush),
    .w_acc   (w_acc),
    .r_acc   (r_acc),
    .level   (level),
    .w_full  (w_full),
    .r_empty (r_empty)
  );

  assign mem_w_en   = w_acc;
  assign mem_w_addr = wptr;
  assign mem_w_data = w_data;
  assign mem_r_en   = r_acc;
  assign mem_r_addr = rptr;
  assign r_data     = mem_r_data;

`ifdef IOB_ASYM_FIFO_CTRL_ERR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (flush) begin
      w_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_en & w_full)  w_overflow  <= 1'b1;
      if (r_en & r_empty) r_underflow <= 1'b1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_iob_asym_fifo_ctrl.sv
// Directed bench: 16->8 controller with a behavioural RAM and byte scoreboard,
// plus an 8->16 instance for the narrow-to-wide lane ordering.
`default_nettype none
module tb_iob_asym_fifo_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- 16 -> 8 instance ----------------
  logic        flush = 1'b0, w_en = 1'b0, r_en = 1'b0;
  logic [15:0] w_data = '0;
  logic        w_full, r_valid, r_empty, mem_w_en, mem_r_en;
  logic [7:0]  r_data, mem_r_data;
  logic [4:0]  level;
  logic [2:0]  mem_w_addr;
  logic [3:0]  mem_r_addr;
  logic [15:0] mem_w_data;
`ifdef IOB_ASYM_FIFO_CTRL_ERR_EN
  logic w_overflow, r_underflow;
`endif

  iob_asym_fifo_ctrl #(.W_DATA_W(16), .R_DATA_W(8), .ADDR_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .w_en(w_en), .w_data(w_data), .w_full(w_full),
    .r_en(r_en), .r_data(r_data), .r_valid(r_valid), .r_empty(r_empty),
    .level(level),
    .mem_w_en(mem_w_en), .mem_w_addr(mem_w_addr), .mem_w_data(mem_w_data),
    .mem_r_en(mem_r_en), .mem_r_addr(mem_r_addr), .mem_r_data(mem_r_data)
`ifdef IOB_ASYM_FIFO_CTRL_ERR_EN
    , .w_overflow(w_overflow), .r_underflow(r_underflow)
`endif
  );

  logic [7:0] mem1 [0:15];
  always @(posedge clk) begin
    if (mem_w_en) begin
      mem1[{mem_w_addr, 1'b0}] <= mem_w_data[7:0];
      mem1[{mem_w_addr, 1'b1}] <= mem_w_data[15:8];
    end
    if (mem_r_en) mem_r_data <= mem1[mem_r_addr];
  end

  // ---------------- 8 -> 16 instance ----------------
  logic        w_en2 = 1'b0, r_en2 = 1'b0;
  logic [7:0]  w_data2 = '0;
  logic        w_full2, r_valid2, r_empty2, mem_w_en2, mem_r_en2;
  logic [15:0] r_data2, mem_r_data2;
  logic [4:0]  level2;
  logic [3:0]  mem_w_addr2;
  logic [2:0]  mem_r_addr2;
  logic [7:0]  mem_w_data2;
`ifdef IOB_ASYM_FIFO_CTRL_ERR_EN
  logic w_overflow2, r_underflow2;
`endif

  iob_asym_fifo_ctrl #(.W_DATA_W(8), .R_DATA_W(16), .ADDR_W(4)) dut_sw (
    .clk(clk), .rst_n(rst_n), .flush(1'b0),
    .w_en(w_en2), .w_data(w_data2), .w_full(w_full2),
    .r_en(r_en2), .r_data(r_data2), .r_valid(r_valid2), .r_empty(r_empty2),
    .level(level2),
    .mem_w_en(mem_w_en2), .mem_w_addr(mem_w_addr2), .mem_w_data(mem_w_data2),
    .mem_r_en(mem_r_en2), .mem_r_addr(mem_r_addr2), .mem_r_data(mem_r_data2)
`ifdef IOB_ASYM_FIFO_CTRL_ERR_EN
    , .w_overflow(w_overflow2), .r_underflow(r_underflow2)
`endif
  );

  logic [7:0] mem2 [0:15];
  always @(posedge clk) begin
    if (mem_w_en2) mem2[mem_w_addr2] <= mem_w_data2;
    if (mem_r_en2) mem_r_data2 <= {mem2[{mem_r_addr2, 1'b1}], mem2[{mem_r_addr2, 1'b0}]};
  end

  // ---------------- reference model for the 16 -> 8 instance ----------------
  logic [7:0] sb[$];
  int lvl = 0;
  int wp  = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One clock with the given requests; acceptance, data and level come from the model.
  task automatic cyc(input logic we, input logic [15:0] wd, input logic re);
    logic       wa, ra;
    logic [7:0] exp_rd;
    w_en = we; w_data = wd; r_en = re;
    #1;
    wa = we && (lvl <= 14);
    ra = re && (lvl >= 1);
    check("mem_w_en", mem_w_en, wa);
    check("mem_r_en", mem_r_en, ra);
    exp_rd = '0;
    if (wa) begin
      check("mem_w_addr", mem_w_addr, wp);
      sb.push_back(wd[7:0]);
      sb.push_back(wd[15:8]);
      wp = (wp + 1) % 8;
    end
    if (ra) exp_rd = sb.pop_front();
    lvl = lvl + (wa ? 2 : 0) - (ra ? 1 : 0);
    @(posedge clk);
    #1;
    w_en = 1'b0; r_en = 1'b0;
    check("r_valid", r_valid, ra);
    if (ra) check("r_data", r_data, exp_rd);
    check("level", level, lvl);
    check("w_full", w_full, lvl > 14);
    check("r_empty", r_empty, lvl < 1);
  endtask

  initial begin
    #200000;
    n_err++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $fatal(1);
  end

  initial begin
    tick(); tick();
    rst_n = 1'b1;
    tick();

    check("rst_r_empty", r_empty, 1);
    check("rst_w_full", w_full, 0);
    check("rst_level", level, 0);
    check("rst_r_valid", r_valid, 0);
    check("rst_mem_w_en", mem_w_en, 0);
    check("rst_mem_r_en", mem_r_en, 0);
    check("rst_r_empty2", r_empty2, 1);

    // Wide word split little-endian into two narrow reads
    cyc(1'b1, 16'hBBAA, 1'b0);
    cyc(1'b0, 16'h0, 1'b1);
    check("lane0", r_data, 8'hAA);
    cyc(1'b0, 16'h0, 1'b1);
    check("lane1", r_data, 8'hBB);
    cyc(1'b0, 16'h0, 1'b0);
    check("empty_after", r_empty, 1);

    // Fill to capacity, then one dropped write
    for (int k = 0; k < 8; k++) cyc(1'b1, 16'h1000 + 16'(k * 16'h0101), 1'b0);
    check("full_level", level, 16);
    check("full_flag", w_full, 1);
    cyc(1'b1, 16'hDEAD, 1'b0);
    check("drop_level", level, 16);
`ifdef IOB_ASYM_FIFO_CTRL_ERR_EN
    check("w_overflow", w_overflow, 1);
    check("r_underflow_clr", r_underflow, 0);
`endif
    // A read while full must not let a write bypass the full flag
    cyc(1'b1, 16'hBEEF, 1'b1);
    check("nobypass_level", level, 15);

    // Drain to 4, then simultaneous write+read
    for (int k = 0; k < 11; k++) cyc(1'b0, 16'h0, 1'b1);
    check("lvl4", level, 4);
    cyc(1'b1, 16'h5A5A, 1'b1);
    check("simul_lvl5", level, 5);

    // Mixed traffic with pointer wrap; scoreboard checks order
    for (int i = 0; i < 20; i++)
      cyc((i % 3) != 2, 16'h0100 + 16'(i * 16'h0203), (i % 4) != 3);
    while (lvl > 0) cyc(1'b0, 16'h0, 1'b1);

    // Flush at level 6, with requests present in the flush cycle
    for (int k = 0; k < 3; k++) cyc(1'b1, 16'h7700 + 16'(k), 1'b0);
    check("lvl6", level, 6);
    flush = 1'b1; w_en = 1'b1; r_en = 1'b1;
    #1;
    check("flush_mem_w_en", mem_w_en, 0);
    check("flush_mem_r_en", mem_r_en, 0);
    tick();
    flush = 1'b0; w_en = 1'b0; r_en = 1'b0;
    check("flush_level", level, 0);
    check("flush_r_empty", r_empty, 1);
    check("flush_r_valid", r_valid, 0);
`ifdef IOB_ASYM_FIFO_CTRL_ERR_EN
    check("flush_ovf_clr", w_overflow, 0);
`endif
    sb.delete(); lvl = 0; wp = 0;
    cyc(1'b0, 16'h0, 1'b1);
`ifdef IOB_ASYM_FIFO_CTRL_ERR_EN
    check("r_underflow", r_underflow, 1);
`endif
    // Read while empty is dropped even with a simultaneous write
    cyc(1'b1, 16'h3344, 1'b1);
    cyc(1'b0, 16'h0, 1'b1);
    check("post_flush_rd", r_data, 8'h44);

    // Narrow -> wide lane order
    w_en2 = 1'b1; w_data2 = 8'h11;
    tick();
    w_en2 = 1'b0;
    check("sw_empty1", r_empty2, 1);
    check("sw_level1", level2, 1);
    w_en2 = 1'b1; w_data2 = 8'h22;
    tick();
    w_en2 = 1'b0;
    check("sw_empty2", r_empty2, 0);
    check("sw_level2", level2, 2);
    r_en2 = 1'b1;
    #1;
    check("sw_mem_r_en", mem_r_en2, 1);
    tick();
    r_en2 = 1'b0;
    check("sw_r_valid", r_valid2, 1);
    check("sw_r_data", r_data2, 16'h2211);
    check("sw_empty3", r_empty2, 1);

    // Asynchronous reset with a read in flight
    cyc(1'b1, 16'hCAFE, 1'b0);
    r_en = 1'b1;
    tick();
    r_en = 1'b0;
    check("inflight_valid", r_valid, 1);
    rst_n = 1'b0;
    #1;
    check("arst_r_valid", r_valid, 0);
    check("arst_level", level, 0);
    check("arst_r_empty", r_empty, 1);
    tick();
    rst_n = 1'b1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
`default_nettype wire
